move_link_scheduler: RTL and testbench
======================================

// Module: move_link_scheduler
// PURPOSE
//   Turn/transfer sequencer for the two-board Connect Four serial link. Sits between the
//   Nios move PIOs and the nibble serializer/deserializer on the shared transfer clock.
//   Decides whose turn it is, launches our move, waits for the remote ACK with timeout and
//   retry, and acknowledges (and de-duplicates) moves received from the other board.
// PARAMETERS
//   ACK_CODE        4'hE  nibble sent/expected as acknowledgement (never a legal column)
//   TIMEOUT_CYCLES  64    clock cycles to wait for ACK before re-sending
//   MAX_RETRIES     3     re-sends allowed before entering LINK_ERROR
// PORTS
//   clock         in   1  transfer clock (master board drives it)
//   reset         in   1  asynchronous, active-high
//   we_are_p1     in   1  1 = we move first after reset
//   submit_toggle in   1  Nios toggles (either edge) to submit our_move
//   our_move      in   4  column 0..7 to send; >7 is illegal
//   tx_busy       in   1  serializer shifting; tx_start ignored while high
//   rx_valid      in   1  one-cycle pulse: rx_nibble holds a complete received nibble
//   rx_nibble     in   4  received nibble
//   tx_start      out  1  one-cycle pulse: serializer loads tx_nibble
//   tx_nibble     out  4  nibble to send (our move or ACK_CODE)
//   our_turn      out  1  high only in LOCAL_TURN
//   their_move    out  4  last accepted remote column
//   move_toggle   out  1  inverts once per newly accepted remote move (Nios edge-detects)
//   bad_submit    out  1  one-cycle pulse: submit with our_move > 7 rejected
//   link_error    out  1  sticky; retries exhausted
// BEHAVIOUR
//   Reset: all outputs 0; state INIT; retry/timeout counters 0; submit_prev <= submit_toggle
//     (no spurious submit on release); pending 0; last_rx valid flag 0.
//   Submit edge: submit_toggle != submit_prev, sampled each cycle; sets pending only in
//     LOCAL_TURN, dropped in every other state.
//   States:
//   INIT: next cycle -> LOCAL_TURN if we_are_p1 else REMOTE_TURN.
//   LOCAL_TURN (our_turn=1): priority 1: rx_valid with rx_nibble == their_move and last_rx
//     valid -> ACK (duplicate; move_toggle unchanged, pending kept). priority 2: pending and
//     our_move<=7 -> latch tx_nibble=our_move, clear pending, retries=0 -> SEND. pending and
//     our_move>7 -> bad_submit pulse, clear pending, stay. Other rx nibbles ignored.
//   SEND: when tx_busy=0 pulse tx_start 1 cycle, clear timeout -> WAIT_ACK; else hold.
//   WAIT_ACK: timeout counts each cycle. rx_valid & rx_nibble==ACK_CODE -> REMOTE_TURN.
//     Count reaches TIMEOUT_CYCLES-1: if retries<MAX_RETRIES, retries+1 -> SEND (same
//     nibble); else link_error=1 -> LINK_ERROR. ACK in the timeout cycle wins.
//   REMOTE_TURN: rx_valid & rx_nibble<=7 -> their_move=rx_nibble, last_rx valid=1,
//     invert move_toggle (same edge) -> ACK. ACK_CODE/8..15 ignored.
//   ACK: tx_nibble=ACK_CODE; when tx_busy=0 pulse tx_start -> LOCAL_TURN.
//   LINK_ERROR: terminal, our_turn=0, tx_start never asserted; exit only by reset.
//   tx_start never asserted on consecutive cycles; tx_nibble stable while in SEND/ACK.
//   Counters saturate-free: timeout width = clog2(TIMEOUT_CYCLES), retries clog2(MAX+1).
//   Reset mid-transfer: immediate return to INIT values; in-flight serializer data discarded.
// TESTING
//   we_are_p1=1, reset release -> our_turn=1 two cycles later; toggle submit, our_move=3,
//     tx_busy=0 -> one tx_start with tx_nibble=3, our_turn=0.
//   After send, rx_valid rx_nibble=4'hE within 64 cycles -> REMOTE_TURN; rx 5 -> their_move=5,
//     move_toggle inverts once, tx_start with 4'hE, our_turn=1.
//   No ACK: tx_start with same nibble at 64-cycle spacing, 4 sends total, then link_error=1,
//     tx_start stays 0 for 500 cycles.
//   LOCAL_TURN, rx 5 again (lost ACK) -> ACK re-sent, move_toggle unchanged; submit our_move=9
//     -> bad_submit pulse, no tx_start.
//   tx_busy held high 10 cycles in SEND -> tx_start delayed to first cycle tx_busy=0; reset
//     asserted in WAIT_ACK -> all outputs 0 asynchronously, submit toggled before reset ignored.

Source files
------------

// File: rtl/move_link_scheduler.sv
// Turn/transfer sequencer for the two-board Connect Four nibble link: launches our move,
// waits for the remote ACK with timeout/retry, and acknowledges (de-duplicated) remote moves.
//
// state       | meaning
// INIT        | one cycle after reset, picks who moves first
// LOCAL_TURN  | our turn, waiting for a submit from the Nios
// SEND        | move nibble latched, waiting for serializer idle
// WAIT_ACK    | move sent, timing the remote ACK
// REMOTE_TURN | waiting for the other board's move
// ACK         | ACK nibble latched, waiting for serializer idle
// LINK_ERROR  | retries exhausted, terminal until reset
module move_link_scheduler #(
    parameter logic [3:0] ACK_CODE       = 4'hE,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter int         MAX_RETRIES    = 3
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_we_are_p1,
    input  logic       i_submit_toggle,
    input  logic [3:0] i_our_move,
    input  logic       i_tx_busy,
    input  logic       i_rx_valid,
    input  logic [3:0] i_rx_nibble,
    output logic       o_tx_start,
    output logic [3:0] o_tx_nibble,
    output logic       o_our_turn,
    output logic [3:0] o_their_move,
    output logic       o_move_toggle,
    output logic       o_bad_submit,
    output logic       o_link_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    // The tx_start cycle is the first cycle of the wait window, so re-sends land
    // exactly TIMEOUT_CYCLES apart.
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_INIT,
        S_LOCAL_TURN,
        S_SEND,
        S_WAIT_ACK,
        S_REMOTE_TURN,
        S_ACK,
        S_LINK_ERROR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_submit_prev;
    logic            r_pending, w_pending_nxt;
    logic            r_last_rx_valid, w_last_rx_valid_nxt;
    logic [3:0]      r_tx_nibble, w_tx_nibble_nxt;
    logic [3:0]      r_their_move, w_their_move_nxt;
    logic            r_move_toggle, w_move_toggle_nxt;
    logic            r_link_error, w_link_error_nxt;
    logic [TW-1:0]   r_timeout, w_timeout_nxt;
    logic [RW-1:0]   r_retries, w_retries_nxt;
    logic            w_submit_edge;

    assign w_submit_edge = i_submit_toggle != r_submit_prev;

    always_comb begin
        w_state_nxt         = r_state;
        w_pending_nxt       = r_pending;
        w_last_rx_valid_nxt = r_last_rx_valid;
        w_tx_nibble_nxt     = r_tx_nibble;
        w_their_move_nxt    = r_their_move;
        w_move_toggle_nxt   = r_move_toggle;
        w_link_error_nxt    = r_link_error;
        w_timeout_nxt       = r_timeout;
        w_retries_nxt       = r_retries;
        o_tx_start          = 1'b0;
        o_bad_submit        = 1'b0;
        o_our_turn          = 1'b0;
        case (r_state)
            S_INIT: w_state_nxt = i_we_are_p1 ? S_LOCAL_TURN : S_REMOTE_TURN;
            S_LOCAL_TURN: begin
                o_our_turn = 1'b1;
                if (w_submit_edge) w_pending_nxt = 1'b1;
                // A repeat of the last remote move means our ACK was lost.
                if (i_rx_valid && r_last_rx_valid && i_rx_nibble == r_their_move) begin
                    w_tx_nibble_nxt = ACK_CODE;
                    w_state_nxt     = S_ACK;
                end else if (r_pending) begin
                    if (!i_our_move[3]) begin
                        w_tx_nibble_nxt = i_our_move;
                        w_retries_nxt   = '0;
                        w_pending_nxt   = 1'b0;
                        w_state_nxt     = S_SEND;
                    end else begin
                        o_bad_submit  = 1'b1;
                        w_pending_nxt = w_submit_edge;
                    end
                end
            end
            S_SEND: begin
                if (!i_tx_busy) begin
                    o_tx_start    = 1'b1;
                    w_timeout_nxt = '0;
                    w_state_nxt   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_rx_valid && i_rx_nibble == ACK_CODE) begin
                    w_state_nxt = S_REMOTE_TURN;
                end else if (r_timeout == TIMEOUT_LAST) begin
                    if (r_retries < RETRY_MAX) begin
                        w_retries_nxt = r_retries + 1'b1;
                        w_state_nxt   = S_SEND;
                    end else begin
                        w_link_error_nxt = 1'b1;
                        w_state_nxt      = S_LINK_ERROR;
                    end
                end else begin
                    w_timeout_nxt = r_timeout + 1'b1;
                end
            end
            S_REMOTE_TURN: begin
                if (i_rx_valid && !i_rx_nibble[3]) begin
                    w_their_move_nxt    = i_rx_nibble;
                    w_last_rx_valid_nxt = 1'b1;
                    w_move_toggle_nxt   = ~r_move_toggle;
                    w_tx_nibble_nxt     = ACK_CODE;
                    w_state_nxt         = S_ACK;
                end
            end
            S_ACK: begin
                if (!i_tx_busy) begin
                    o_tx_start  = 1'b1;
                    w_state_nxt = S_LOCAL_TURN;
                end
            end
            S_LINK_ERROR: w_state_nxt = S_LINK_ERROR;
            default:      w_state_nxt = S_INIT;
        endcase
    end

    // submit_prev follows the toggle through reset so releasing reset is never a submit.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= S_INIT;
            r_submit_prev   <= i_submit_toggle;
            r_pending       <= 1'b0;
            r_last_rx_valid <= 1'b0;
            r_tx_nibble     <= '0;
            r_their_move    <= '0;
            r_move_toggle   <= 1'b0;
            r_link_error    <= 1'b0;
            r_timeout       <= '0;
            r_retries       <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_submit_prev   <= i_submit_toggle;
            r_pending       <= w_pending_nxt;
            r_last_rx_valid <= w_last_rx_valid_nxt;
            r_tx_nibble     <= w_tx_nibble_nxt;
            r_their_move    <= w_their_move_nxt;
            r_move_toggle   <= w_move_toggle_nxt;
            r_link_error    <= w_link_error_nxt;
            r_timeout       <= w_timeout_nxt;
            r_retries       <= w_retries_nxt;
        end
    end

    assign o_tx_nibble   = r_tx_nibble;
    assign o_their_move  = r_their_move;
    assign o_move_toggle = r_move_toggle;
    assign o_link_error  = r_link_error;

endmodule

// File: tb/tb_move_link_scheduler.sv
// Scenario bench for move_link_scheduler: random moves, ACK delays and busy lengths,
// expectations derived from the link protocol rules (turn order, 64-cycle resend, 4 sends max).
module tb_move_link_scheduler;

    localparam logic [3:0] ACK = 4'hE;
    localparam int SPACING = 64;
    localparam int SENDS = 4;

    logic       clk;
    logic       rst;
    logic       we_are_p1;
    logic       submit_toggle;
    logic [3:0] our_move;
    logic       tx_busy;
    logic       rx_valid;
    logic [3:0] rx_nibble;
    logic       tx_start;
    logic [3:0] tx_nibble;
    logic       our_turn;
    logic [3:0] their_move;
    logic       move_toggle;
    logic       bad_submit;
    logic       link_error;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_bad = 0;
    int         n_consec = 0;
    bit         prev_start = 0;
    int         start_cyc[$];
    logic [3:0] start_nib[$];
    logic [3:0] exp_their;
    logic       exp_toggle;

    move_link_scheduler dut (
        .i_clock(clk), .i_reset(rst), .i_we_are_p1(we_are_p1),
        .i_submit_toggle(submit_toggle), .i_our_move(our_move), .i_tx_busy(tx_busy),
        .i_rx_valid(rx_valid), .i_rx_nibble(rx_nibble),
        .o_tx_start(tx_start), .o_tx_nibble(tx_nibble), .o_our_turn(our_turn),
        .o_their_move(their_move), .o_move_toggle(move_toggle),
        .o_bad_submit(bad_submit), .o_link_error(link_error)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus plus monitoring; inputs change at negedge, outputs sampled 1 later.
    task automatic step(input logic v, input logic [3:0] nib, input logic busy);
        @(negedge clk);
        rx_valid = v;
        rx_nibble = nib;
        tx_busy = busy;
        #1;
        if (tx_start) begin
            start_cyc.push_back(cyc);
            start_nib.push_back(tx_nibble);
            if (prev_start) n_consec++;
        end
        prev_start = tx_start;
        if (bad_submit) n_bad++;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1; we_are_p1 = 1; rx_valid = 0; tx_busy = 0; our_move = 3;
        submit_toggle = 1'($urandom);
        #1;
        n_tests++;
        if ({tx_start, tx_nibble, our_turn, their_move, move_toggle, bad_submit, link_error} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {tx_start, tx_nibble, our_turn, their_move, move_toggle, bad_submit, link_error});
        end
        repeat (2) @(negedge clk);
        submit_toggle = ~submit_toggle;
        @(negedge clk);
        rst = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        n_tests++;
        if (our_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_turn: our_turn=%b expected 1", our_turn);
        end
        repeat (5) step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != 0 || our_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_spurious_submit: starts=%0d our_turn=%b expected 0/1",
                     start_cyc.size(), our_turn);
        end
        exp_their = 0;
        exp_toggle = 0;
    endtask

    // Remote side sends ACK after ack_delay cycles then its own move; we must ACK it back.
    task automatic finish_round(input int ack_delay, input int base);
        logic [3:0] r;
        repeat (ack_delay - 1) step(0, 0, 0);
        step(1, ACK, 0);
        step(0, 0, 0);
        step(1, 4'($urandom_range(8, 15)), 0);
        n_tests++;
        if (start_cyc.size() != base || our_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL acked_no_resend: starts=%0d our_turn=%b expected %0d/0",
                     start_cyc.size(), our_turn, base);
        end
        r = 4'($urandom_range(0, 7));
        step(1, r, 0);
        exp_their = r;
        exp_toggle = ~exp_toggle;
        step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 1 || start_nib[start_nib.size()-1] !== ACK) begin
            n_fail++;
            $display("FAIL remote_ack_sent: starts=%0d nib=%h expected %0d/%h",
                     start_cyc.size(), start_nib[start_nib.size()-1], base + 1, ACK);
        end
        step(0, 0, 0);
        n_tests++;
        if (our_turn !== 1'b1 || their_move !== exp_their || move_toggle !== exp_toggle) begin
            n_fail++;
            $display("FAIL remote_move_taken: turn=%b their=%h tog=%b expected 1/%h/%b",
                     our_turn, their_move, move_toggle, exp_their, exp_toggle);
        end
    endtask

    task automatic test_send_ack();
        for (int round = 0; round < 3; round++) begin
            logic [3:0] m;
            int base;
            m = 4'($urandom_range(0, 7));
            our_move = m;
            submit_toggle = ~submit_toggle;
            base = start_cyc.size();
            for (int i = 0; i < 10 && start_cyc.size() == base; i++) step(0, 0, 0);
            n_tests++;
            if (start_cyc.size() != base + 1 || start_nib[base] !== m || our_turn !== 1'b0) begin
                n_fail++;
                $display("FAIL send_move: starts=%0d nib=%h turn=%b expected %0d/%h/0",
                         start_cyc.size(), start_nib[start_nib.size()-1], our_turn, base + 1, m);
            end
            finish_round($urandom_range(1, 50), base + 1);
        end
    endtask

    task automatic test_busy();
        logic [3:0] m;
        int base;
        int k;
        m = 4'($urandom_range(0, 7));
        k = $urandom_range(4, 12);
        our_move = m;
        submit_toggle = ~submit_toggle;
        base = start_cyc.size();
        repeat (k) step(0, 0, 1);
        n_tests++;
        if (start_cyc.size() != base) begin
            n_fail++;
            $display("FAIL busy_holds_send: starts=%0d expected %0d", start_cyc.size(), base);
        end
        step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 1 || start_cyc[start_cyc.size()-1] != cyc - 1 ||
            start_nib[start_nib.size()-1] !== m) begin
            n_fail++;
            $display("FAIL busy_release_send: starts=%0d nib=%h expected %0d/%h at first idle cycle",
                     start_cyc.size(), start_nib[start_nib.size()-1], base + 1, m);
        end
        step(1, ACK, 0);
        step(0, 0, 0);
        step(1, 4'($urandom_range(0, 7)), 0);
        exp_their = rx_nibble;
        exp_toggle = ~exp_toggle;
        repeat (3) step(0, 0, 1);
        n_tests++;
        if (start_cyc.size() != base + 1) begin
            n_fail++;
            $display("FAIL busy_holds_ack: starts=%0d expected %0d", start_cyc.size(), base + 1);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 2 || start_nib[start_nib.size()-1] !== ACK || our_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release_ack: starts=%0d nib=%h turn=%b expected %0d/%h/1",
                     start_cyc.size(), start_nib[start_nib.size()-1], our_turn, base + 2, ACK);
        end
    endtask

    task automatic test_duplicate_and_bad();
        logic [3:0] m;
        logic [3:0] other;
        int base;
        int bbase;
        other = 4'((32'(exp_their) + 1 + $urandom_range(0, 6)) % 8);
        base = start_cyc.size();
        step(1, other, 0);
        repeat (3) step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base || our_turn !== 1'b1 || their_move !== exp_their) begin
            n_fail++;
            $display("FAIL local_ignores_new_rx: starts=%0d turn=%b their=%h expected %0d/1/%h",
                     start_cyc.size(), our_turn, their_move, base, exp_their);
        end
        bbase = n_bad;
        our_move = 4'($urandom_range(8, 15));
        submit_toggle = ~submit_toggle;
        repeat (4) step(0, 0, 0);
        n_tests++;
        if (n_bad != bbase + 1 || start_cyc.size() != base || our_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_submit: pulses=%0d starts=%0d turn=%b expected %0d/%0d/1",
                     n_bad - bbase, start_cyc.size(), our_turn, 1, base);
        end
        m = 4'($urandom_range(0, 7));
        our_move = m;
        submit_toggle = ~submit_toggle;
        step(1, exp_their, 0);
        repeat (4) step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 2 || start_nib[base] !== ACK || start_nib[base+1] !== m) begin
            n_fail++;
            $display("FAIL duplicate_then_pending: starts=%0d expected %0d with ACK then %h",
                     start_cyc.size() - base, 2, m);
        end
        n_tests++;
        if (move_toggle !== exp_toggle || their_move !== exp_their) begin
            n_fail++;
            $display("FAIL duplicate_no_toggle: tog=%b their=%h expected %b/%h",
                     move_toggle, their_move, exp_toggle, exp_their);
        end
        finish_round($urandom_range(1, 40), base + 2);
    endtask

    task automatic test_retry_error();
        int base;
        int after;
        our_move = 4'd7;
        submit_toggle = ~submit_toggle;
        base = start_cyc.size();
        repeat (300) step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + SENDS) begin
            n_fail++;
            $display("FAIL retry_count: sends=%0d expected %0d", start_cyc.size() - base, SENDS);
        end else begin
            for (int i = 0; i < SENDS; i++) begin
                n_tests++;
                if (start_nib[base+i] !== 4'd7 ||
                    (i > 0 && start_cyc[base+i] - start_cyc[base+i-1] != SPACING)) begin
                    n_fail++;
                    $display("FAIL retry_send_%0d: nib=%h gap=%0d expected 7/%0d", i,
                             start_nib[base+i], i > 0 ? start_cyc[base+i] - start_cyc[base+i-1] : 0,
                             SPACING);
                end
            end
        end
        n_tests++;
        if (link_error !== 1'b1 || our_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL link_error_set: err=%b turn=%b expected 1/0", link_error, our_turn);
        end
        after = start_cyc.size();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) submit_toggle = ~submit_toggle;
            step(1'($urandom), 4'($urandom), 1'($urandom));
        end
        n_tests++;
        if (start_cyc.size() != after || link_error !== 1'b1 || our_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL link_error_terminal: extra_starts=%0d err=%b turn=%b expected 0/1/0",
                     start_cyc.size() - after, link_error, our_turn);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        @(negedge clk);
        rst = 1; rx_valid = 0; tx_busy = 0; we_are_p1 = 1;
        @(negedge clk);
        rst = 0;
        step(0, 0, 0);
        step(0, 0, 0);
        our_move = 4'($urandom_range(0, 7));
        submit_toggle = ~submit_toggle;
        base = start_cyc.size();
        for (int i = 0; i < 10 && start_cyc.size() == base; i++) step(0, 0, 0);
        repeat (5) step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 1 || our_turn !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_reset_wait_ack: starts=%0d turn=%b expected %0d/0",
                     start_cyc.size(), our_turn, base + 1);
        end
        submit_toggle = ~submit_toggle;
        #2;
        rst = 1;
        #1;
        n_tests++;
        if ({tx_start, tx_nibble, our_turn, their_move, move_toggle, bad_submit, link_error} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {tx_start, tx_nibble, our_turn, their_move, move_toggle, bad_submit, link_error});
        end
        exp_their = 0;
        exp_toggle = 0;
        @(negedge clk);
        we_are_p1 = 0;
        @(negedge clk);
        rst = 0;
        base = start_cyc.size();
        repeat (3) step(0, 0, 0);
        step(1, 4'd8, 0);
        step(1, ACK, 0);
        step(0, 0, 0);
        n_tests++;
        if (our_turn !== 1'b0 || start_cyc.size() != base || move_toggle !== 1'b0) begin
            n_fail++;
            $display("FAIL p2_remote_ignores_illegal: turn=%b starts=%0d tog=%b expected 0/%0d/0",
                     our_turn, start_cyc.size() - base, move_toggle, 0);
        end
        step(1, 4'd7, 0);
        exp_their = 7;
        exp_toggle = 1;
        step(0, 0, 0);
        n_tests++;
        if (start_cyc.size() != base + 1 || start_nib[start_nib.size()-1] !== ACK ||
            their_move !== exp_their || move_toggle !== exp_toggle) begin
            n_fail++;
            $display("FAIL p2_accepts_col7: starts=%0d their=%h tog=%b expected 1/%h/%b",
                     start_cyc.size() - base, their_move, move_toggle, exp_their, exp_toggle);
        end
        step(0, 0, 0);
        n_tests++;
        if (our_turn !== 1'b1) begin
            n_fail++;
            $display("FAIL p2_turn_after_ack: turn=%b expected 1", our_turn);
        end
    endtask

    initial begin
        rst = 1; we_are_p1 = 1; submit_toggle = 0; our_move = 0;
        tx_busy = 0; rx_valid = 0; rx_nibble = 0;
        exp_their = 0; exp_toggle = 0;
        test_reset();
        test_send_ack();
        test_busy();
        test_duplicate_and_bad();
        test_retry_error();
        test_reset_mid();
        n_tests++;
        if (n_consec != 0) begin
            n_fail++;
            $display("FAIL back_to_back_tx_start: consecutive=%0d expected 0", n_consec);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
